fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory. Honours the stall controls PCWrite/IF_ID_Write from the load-use hazard unit, and the branch/jump redirect from EX. Its IF_ID_* outputs feed the decode stage and the hazard unit's rs1/rs2 comparison.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word driven on bubbles (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
PCWrite  in  1  1 = PC may advance (from hazard unit)
IF_ID_Write  in  1  1 = IF/ID register may update (from hazard unit)
flush  in  1  redirect request from EX (taken branch/jump)
branch_target  in  XLEN  redirect PC; bits[1:0] ignored, treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  XLEN  fetch address; sampled only on valid&&ready
imem_rsp_valid  in  1  response valid, one per accepted request, 1+ cycles later
imem_rsp_data  in  32  instruction word
IF_ID_PC  out  XLEN  PC of instruction in IF/ID
IF_ID_PC4  out  XLEN  IF_ID_PC + 4
IF_ID_Instr  out  32  instruction in IF/ID
IF_ID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, any time incl. mid-transaction): pc=RESET_PC, state=REQ, kill=0, buffer invalid; IF_ID_PC=0, IF_ID_PC4=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0. An in-flight response arriving after reset release while in REQ is ignored; memory must not hold responses across reset.
- Outputs: imem_req_valid=1 only in REQ; imem_addr=pc in all states.
- FSM states REQ, WAIT, HOLD. "deliver" = IF_ID_Write && PCWrite.
- REQ: on valid&&ready -> WAIT. Otherwise stay.
- WAIT: on rsp_valid with kill=1 -> discard, kill<=0, -> REQ. On rsp_valid with kill=0 and deliver -> IF/ID<={pc, pc+4, data, 1}, pc<=pc+4, -> REQ. On rsp_valid without deliver -> buffer<=data, -> HOLD.
- HOLD: when deliver -> IF/ID loaded from buffer as above, pc<=pc+4, -> REQ.
- Every cycle with IF_ID_Write=1 and no delivery: IF_ID_Valid<=0, IF_ID_Instr<=NOP_INSTR (bubble). IF_ID_PC/PC4 hold.
- IF_ID_Write=0: all IF_ID_* hold. PCWrite=0: pc holds.
- Fetch-to-IF/ID latency: request accept at cycle N, response at N+k -> IF_ID valid at N+k+1; next request issues at N+k+1. Peak throughput is 1 instr per 2 cycles with zero-wait memory.
- flush has priority over all stall inputs and over delivery:
  - IF_ID_Valid<=0, IF_ID_Instr<=NOP_INSTR, pc<={branch_target[XLEN-1:2],2'b00}.
  - REQ with handshake this cycle (addr = old pc): kill<=1, -> WAIT. REQ without handshake: stay REQ, new address next cycle.
  - WAIT with rsp_valid this cycle: discard, -> REQ. WAIT without rsp: kill<=1, stay WAIT.
  - HOLD: drop buffer, -> REQ.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
- At most one request outstanding. No request issues while in WAIT or HOLD.

Test Plan:
- Reset, then zero-wait memory returning 0x00A00093 at 0x0 and 0x00100113 at 0x4 -> IF_ID_PC 0x0 then 0x4, IF_ID_Valid pulses per delivery, bubbles between; IF_ID_PC4=0x4/0x8.
- Response with IF_ID_Write=PCWrite=0 for 3 cycles -> state HOLD, IF_ID unchanged, no new imem request. Release -> buffered instr appears next cycle, pc+4.
- flush with target 0x103 while WAIT (rsp 2 cycles later) -> stale response discarded, next request addr 0x100, IF_ID_Valid=0 until 0x100 delivered.
- flush in same cycle as rsp_valid and IF_ID_Write=0 -> IF_ID_Valid=0, response dropped, next request addr=target.
- pc=0xFFFF_FFFC delivery -> next imem_addr 0x0000_0000, IF_ID_PC4=0x0.
- rst_n asserted while WAIT -> all outputs at reset values immediately (asynchronously), first request addr RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Keeps one request in flight to a variable-latency instruction memory, parks a
// response in a one-entry buffer while decode is stalled, and discards stale
// responses after a redirect.
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCWrite,
   input  logic            IF_ID_Write,
   input  logic            flush,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [XLEN-1:0] IF_ID_PC4,
   output logic [31:0]     IF_ID_Instr,
   output logic            IF_ID_Valid
);

   typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              kill_q, kill_d;
   logic [31:0]       buf_q, buf_d;
   logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
   logic [XLEN-1:0]   if_id_pc4_q, if_id_pc4_d;
   logic [31:0]       if_id_instr_q, if_id_instr_d;
   logic              if_id_valid_q, if_id_valid_d;

   logic              deliver;
   logic              load;
   logic [31:0]       load_data;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   redirect_pc;
   logic              unused_tgt_lsbs;

   assign deliver         = IF_ID_Write && PCWrite;
   assign pc_plus4        = pc_q + XLEN'(4);
   // Targets are word aligned; the low two bits are dropped on purpose.
   assign redirect_pc     = {branch_target[XLEN-1:2], 2'b00};
   assign unused_tgt_lsbs = ^branch_target[1:0];

   assign imem_req_valid = (state_q == StReq);
   assign imem_addr      = pc_q;
   assign IF_ID_PC       = if_id_pc_q;
   assign IF_ID_PC4      = if_id_pc4_q;
   assign IF_ID_Instr    = if_id_instr_q;
   assign IF_ID_Valid    = if_id_valid_q;

   // Next-state: fetch FSM, PC update and IF/ID load/bubble; flush wins over everything.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_d        = kill_q;
      buf_d         = buf_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      load          = 1'b0;
      load_data     = imem_rsp_data;

      if (flush) begin
         pc_d          = redirect_pc;
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         unique case (state_q)
            StReq: begin
               // Request accepted this cycle still carries the old PC: mark it stale.
               if (imem_req_ready) begin
                  kill_d  = 1'b1;
                  state_d = StWait;
               end
            end
            StWait: begin
               if (imem_rsp_valid) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            StHold:  state_d = StReq;
            default: state_d = StReq;
         endcase
      end else begin
         unique case (state_q)
            StReq: begin
               if (imem_req_ready) state_d = StWait;
            end
            StWait: begin
               if (imem_rsp_valid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = StReq;
                  end else if (deliver) begin
                     load      = 1'b1;
                     load_data = imem_rsp_data;
                  end else begin
                     buf_d   = imem_rsp_data;
                     state_d = StHold;
                  end
               end
            end
            StHold: begin
               if (deliver) begin
                  load      = 1'b1;
                  load_data = buf_q;
               end
            end
            default: state_d = StReq;
         endcase

         if (load) begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
            if_id_instr_d = load_data;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
            state_d       = StReq;
         end else if (IF_ID_Write) begin
            // Nothing to hand over: insert a bubble, keep the PC fields.
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StReq;
         pc_q          <= RESET_PC;
         kill_q        <= 1'b0;
         buf_q         <= NOP_INSTR;
         if_id_pc_q    <= '0;
         if_id_pc4_q   <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         kill_q        <= kill_d;
         buf_q         <= buf_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a driver applies inputs and a memory model each cycle and
// queues a record of the cycle; a monitor pops each record after the clock edge,
// advances a transaction-level reference model and compares the DUT outputs.
module tb_fetch_stage;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        PCWrite = 1'b0;
   logic        IF_ID_Write = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_PC4;
   logic [31:0] IF_ID_Instr;
   logic        IF_ID_Valid;

   always #5 clk = ~clk;

   fetch_stage #(
      .XLEN      (32),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .PCWrite        (PCWrite),
      .IF_ID_Write    (IF_ID_Write),
      .flush          (flush),
      .branch_target  (branch_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .IF_ID_PC       (IF_ID_PC),
      .IF_ID_PC4      (IF_ID_PC4),
      .IF_ID_Instr    (IF_ID_Instr),
      .IF_ID_Valid    (IF_ID_Valid)
   );

   typedef struct {
      bit          fl;
      logic [31:0] tgt;
      bit          wr;
      bit          pcw;
      bit          hs;
      logic [31:0] addr;
      bit          rsp;
      logic [31:0] data;
   } rec_t;

   rec_t        rec_q[$];
   int          total = 0;
   int          bad = 0;
   bit          end_req = 1'b0;

   // Memory model state (driver side only).
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = '0;
   int          lat_fix = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h00A0_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: memory response, request handshake, control inputs.
   task automatic cycle(input bit fl, input logic [31:0] tgt, input bit wr, input bit pcw,
                        input bit rdy);
      rec_t r;
      @(negedge clk);
      r.rsp  = 1'b0;
      r.data = '0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            r.rsp  = 1'b1;
            r.data = mem_word(paddr);
            pend   = 1'b0;
         end
      end
      r.hs   = imem_req_valid && rdy;
      r.addr = imem_addr;
      if (r.hs) begin
         pend  = 1'b1;
         paddr = imem_addr;
         cnt   = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      end
      r.fl = fl; r.tgt = tgt; r.wr = wr; r.pcw = pcw;
      flush          = fl;
      branch_target  = tgt;
      IF_ID_Write    = wr;
      PCWrite        = pcw;
      imem_req_ready = rdy;
      imem_rsp_valid = r.rsp;
      imem_rsp_data  = r.data;
      rec_q.push_back(r);
   endtask

   // Idle cycles with ready low: lets any pending fetch drain and parks the FSM in REQ.
   task automatic to_req();
      repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic drive_idle();
      flush          = 1'b0;
      IF_ID_Write    = 1'b0;
      PCWrite        = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
   endtask

   // Monitor: reference model in terms of fetch transactions and the program-order PC.
   initial begin
      logic [31:0] exp_pc, m_pc, m_pc4, m_instr, f_data;
      bit          m_valid, f_ex, f_live, f_have, dlv;
      int          n_del;
      rec_t        r;
      exp_pc = RST_PC; m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0;
      f_ex = 1'b0; f_live = 1'b0; f_have = 1'b0; f_data = '0; n_del = 0;
      forever begin
         @(posedge clk or negedge rst_n or posedge end_req);
         if (end_req) begin
            chk("enough_deliveries", 32'(n_del >= 100), 32'd1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end else if (!rst_n) begin
            #1;
            chk("rst_if_id_pc", IF_ID_PC, 32'h0);
            chk("rst_if_id_pc4", IF_ID_PC4, 32'h0);
            chk("rst_if_id_instr", IF_ID_Instr, NOP);
            chk("rst_if_id_valid", 32'(IF_ID_Valid), 32'd0);
            chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
            chk("rst_imem_addr", imem_addr, RST_PC);
            exp_pc = RST_PC; m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0;
            f_ex = 1'b0; f_live = 1'b0; f_have = 1'b0;
            rec_q.delete();
         end else begin
            #1;
            if (rec_q.size() != 0) begin
               r   = rec_q.pop_front();
               dlv = 1'b0;
               if (r.hs) begin
                  chk("req_addr", r.addr, exp_pc);
                  chk("single_outstanding", 32'(f_ex), 32'd0);
               end
               if (r.rsp && f_ex) begin
                  if (!f_live) f_ex = 1'b0;
                  else begin
                     f_have = 1'b1;
                     f_data = r.data;
                  end
               end
               if (r.fl) begin
                  m_valid = 1'b0;
                  m_instr = NOP;
                  if (f_ex && f_have) f_ex = 1'b0;
                  else if (f_ex) f_live = 1'b0;
                  exp_pc = {r.tgt[31:2], 2'b00};
                  if (r.hs) begin f_ex = 1'b1; f_live = 1'b0; f_have = 1'b0; end
               end else begin
                  if (f_ex && f_live && f_have && r.wr && r.pcw) begin
                     m_pc    = exp_pc;
                     m_pc4   = exp_pc + 32'd4;
                     m_instr = f_data;
                     m_valid = 1'b1;
                     exp_pc  = exp_pc + 32'd4;
                     f_ex    = 1'b0;
                     dlv     = 1'b1;
                     n_del++;
                  end
                  if (r.wr && !dlv) begin
                     m_valid = 1'b0;
                     m_instr = NOP;
                  end
                  if (r.hs) begin f_ex = 1'b1; f_live = 1'b1; f_have = 1'b0; end
               end
               chk("if_id_valid", 32'(IF_ID_Valid), 32'(m_valid));
               chk("if_id_instr", IF_ID_Instr, m_instr);
               chk("if_id_pc", IF_ID_PC, m_pc);
               chk("if_id_pc4", IF_ID_PC4, m_pc4);
               chk("imem_addr", imem_addr, exp_pc);
               chk("req_valid", 32'(imem_req_valid), 32'(!f_ex));
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      logic [31:0] tgt;
      int          sel;
      bit          wr, pcw;
      #2 rst_n = 1'b0;
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait memory: 0x0 and 0x4 delivered with bubbles between.
      lat_fix = 1;
      repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Response arrives under a full stall and is buffered, then released.
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Redirect to 0x103 while waiting: stale response dropped, fetch from 0x100.
      lat_fix = 3;
      to_req();
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Redirect coinciding with the response while IF/ID is stalled.
      lat_fix = 2;
      to_req();
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // PC wrap at the top of the address space.
      lat_fix = 1;
      to_req();
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
      repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Asynchronous reset while a fetch is outstanding.
      lat_fix = 3;
      to_req();
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      pend  = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Randomized traffic.
      lat_fix = 0;
      repeat (3000) begin
         sel = int'($urandom % 3);
         if (sel == 0) tgt = $urandom;
         else if (sel == 1) tgt = $urandom % 256;
         else tgt = 32'hFFFF_FFF0 | ($urandom % 16);
         sel = int'($urandom % 10);
         wr  = (sel < 7) || (sel == 8);
         pcw = (sel < 7) || (sel == 9);
         cycle(($urandom % 100) < 5, tgt, wr, pcw, ($urandom % 4) != 0);
      end

      @(posedge clk);
      #3;
      end_req = 1'b1;
      repeat (20) @(posedge clk);
      $display("FAIL watchdog: monitor did not finish");
      $fatal(1, "monitor did not finish");
   end

endmodule
